// File: rtl/bus_arbiter.sv
// bus_arbiter: merges the core's instruction and data valid/ready ports
// onto a single downstream memory bus. One transfer is captured at a time.
// The captured request stays stable on mem_* until mem_ready, and the response
// is routed back to the master that owns the transfer.
// Tie-break is fixed (data first) or round-robin, chosen by ROUND_ROBIN.

module bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_r;
    logic        last_d_r;
    logic        mem_valid_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wstrb_r;
    logic [1:0]  grant_r;

    logic        pick_d_s;
    logic        any_req_s;

    assign any_req_s = i_valid | d_valid;

    // Arbitration: choose the data master when it alone requests or wins a tie
    always_comb begin
        pick_d_s = 1'b0;
        if (i_valid && d_valid) begin
            if (ROUND_ROBIN == 1'b1) begin
                // Grant whichever master did not own the previous transfer
                pick_d_s = ~last_d_r;
            end else begin
                pick_d_s = 1'b1;
            end
        end else if (d_valid) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Transfer FSM: capture the winner in IDLE, hold the bus until mem_ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            last_d_r    <= 1'b1;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            grant_r     <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        mem_valid_r <= 1'b1;
                        last_d_r    <= pick_d_s;
                        if (pick_d_s) begin
                            state_r     <= BUSY_D;
                            grant_r     <= 2'b10;
                            mem_addr_r  <= d_addr;
                            mem_wdata_r <= d_wdata;
                            mem_wstrb_r <= d_wstrb;
                        end else begin
                            state_r     <= BUSY_I;
                            grant_r     <= 2'b01;
                            mem_addr_r  <= i_addr;
                            mem_wdata_r <= i_wdata;
                            mem_wstrb_r <= i_wstrb;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Master valid is not consulted: a captured transfer always completes
                    if (mem_ready) begin
                        state_r     <= IDLE;
                        mem_valid_r <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                        grant_r     <= 2'b00;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_valid_r <= 1'b0;
                    mem_wstrb_r <= 4'b0000;
                    grant_r     <= 2'b00;
                end
            endcase
        end
    end

    // Response routing: zero-latency ready and read data to the owning master only
    always_comb begin
        i_ready = 1'b0;
        d_ready = 1'b0;
        i_rdata = 32'h0000_0000;
        d_rdata = 32'h0000_0000;
        case (state_r)
            BUSY_I: begin
                if (mem_ready) begin
                    i_ready = 1'b1;
                    i_rdata = mem_rdata;
                end else begin
                    i_ready = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_ready = 1'b1;
                    d_rdata = mem_rdata;
                end else begin
                    d_ready = 1'b0;
                end
            end
            default: begin
                i_ready = 1'b0;
                d_ready = 1'b0;
            end
        endcase
    end

    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign grant     = grant_r;

endmodule
